// File: rtl/mem_port_pkg.sv
// Shared types for the memory port front end: the request/response beat,
// the channel-index type and the largest supported channel count.
package mem_port_pkg;

  localparam int MEM_PORT_MAX_CH   = 8;
  localparam int MEM_PORT_CH_IDX_W = $clog2(MEM_PORT_MAX_CH);
  localparam int MEM_PORT_ID_W     = 16;

  // Wide enough to name any channel up to the maximum supported count.
  typedef logic [MEM_PORT_CH_IDX_W-1:0] ch_idx_t;

  // One beat on any request or response port; access_id carries the channel tag.
  typedef struct packed {
    logic                     vld;
    logic                     we;
    logic [31:0]              addr;
    logic [31:0]              data;
    logic [MEM_PORT_ID_W-1:0] access_id;
  } request_t;

  // Channel that follows cur, wrapping from num_ch-1 back to channel 0.
  function automatic ch_idx_t ch_wrap_inc(input ch_idx_t cur, input int num_ch);
    if (int'(cur) >= num_ch - 1) return '0;
    return cur + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Request arbiter for mem_port_router: eligibility vector in, one-hot grant out.
// Build option: define MEM_PORT_RR_ARB_EN for round-robin arbitration with an
// internal pointer; left undefined, the lowest-index eligible channel wins and
// no pointer state exists (the clock/reset ports are only present with it).
module mem_port_arb
  import mem_port_pkg::*;
#(
  parameter int NUM_CH = 2
) (
`ifdef MEM_PORT_RR_ARB_EN
  input  logic              clk,
  input  logic              reset,
`endif
  input  logic              enable,
  input  logic [NUM_CH-1:0] elig,
  output logic [NUM_CH-1:0] grant
);

  // Keeps only the lowest set bit of v.
  function automatic logic [NUM_CH-1:0] pick_lowest(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i] && (r == '0)) r[i] = 1'b1;
    end
    return r;
  endfunction

`ifdef MEM_PORT_RR_ARB_EN
  ch_idx_t           rr_ptr;
  ch_idx_t           gnt_idx;
  logic [NUM_CH-1:0] upper;

  // Prefer channels above the last winner; fall back to the lowest eligible one,
  // which is the same as searching from rr_ptr+1 with wrap-around.
  always_comb begin
    upper   = '0;
    grant   = '0;
    gnt_idx = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      upper[i] = elig[i] && (i > int'(rr_ptr));
    end
    if (enable) begin
      grant = pick_lowest((upper != '0) ? upper : elig);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) gnt_idx = ch_idx_t'(i);
    end
  end

  // Remember the winner; the pointer only moves when something is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= ch_idx_t'(NUM_CH - 1);
    end else if (grant != '0) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  // Fixed priority: channel 0 always wins when it is eligible.
  always_comb begin
    grant = '0;
    if (enable) begin
      grant = pick_lowest(elig);
    end
  end
`endif

endmodule

// File: rtl/mem_port_router.sv
// Per-core memory port front end. Arbitrates NUM_CH requestor channels onto one
// registered memory request slot, tracks outstanding requests per channel and
// routes memory responses back using the channel field inside access_id.
// reset is asynchronous and active-low.
// Build option: MEM_PORT_RR_ARB_EN selects round-robin arbitration in
// mem_port_arb; without it arbitration is fixed priority (channel 0 highest).
module mem_port_router
  import mem_port_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int CH_ID_LSB       = 6,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  request_t          ch_req [NUM_CH],
  output logic [NUM_CH-1:0] grant,
  output request_t          ch_rsp [NUM_CH],
  output request_t          mem_req,
  input  logic              mem_req_ready,
  input  request_t          mem_rsp,
  output logic              route_err
);

  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  out_cnt [NUM_CH];
  logic              slot_free;
  logic              arb_en;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] cnt_zero;
  logic [NUM_CH-1:0] rsp_hit;
  logic [CH_W-1:0]   rsp_field;
  logic              rsp_bad;
  logic              zero_hit;
  request_t          next_req;

  // The slot can take a new request when it is empty or being drained this cycle;
  // no grant is ever issued while reset is held.
  assign slot_free = !mem_req.vld || mem_req_ready;
  assign arb_en    = slot_free && reset;
  assign rsp_field = mem_rsp.access_id[CH_ID_LSB +: CH_W];

  // Per-channel eligibility and response decode.
  always_comb begin
    elig     = '0;
    cnt_zero = '0;
    rsp_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_zero[i] = (out_cnt[i] == '0);
      elig[i]     = ch_req[i].vld && (out_cnt[i] < CNT_MAX);
      rsp_hit[i]  = mem_rsp.vld && (rsp_field == CH_W'(i));
    end
    rsp_bad  = mem_rsp.vld && (rsp_hit == '0);
    zero_hit = (rsp_hit & cnt_zero) != '0;
  end

  // Select the granted channel's request without a variable array index.
  always_comb begin
    next_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) next_req = ch_req[i];
    end
  end

  mem_port_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
`ifdef MEM_PORT_RR_ARB_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .enable (arb_en),
    .elig   (elig),
    .grant  (grant)
  );

  // Output slot: load on grant, empty when free with no winner, hold under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req <= '0;
    end else if (slot_free) begin
      if (grant != '0) begin
        mem_req <= next_req;
      end else begin
        mem_req.vld <= 1'b0;
      end
    end
  end

  // Outstanding counters: +1 on grant, -1 on a routed response, both cancel,
  // and a response to an idle channel leaves the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i] && !rsp_hit[i]) begin
          out_cnt[i] <= out_cnt[i] + CNT_ONE;
        end else if (!grant[i] && rsp_hit[i] && !cnt_zero[i]) begin
          out_cnt[i] <= out_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Response routing: the addressed channel gets the beat, every other valid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) ch_rsp[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rsp_hit[i]) begin
          ch_rsp[i] <= mem_rsp;
        end else begin
          ch_rsp[i].vld <= 1'b0;
        end
      end
    end
  end

  // Sticky error for unroutable responses or responses with nothing outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_err <= 1'b0;
    end else if (rsp_bad || zero_hit) begin
      route_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_router.sv
// Directed testbench for mem_port_router with NUM_CH=3, MAX_OUTSTANDING=3.
// Expected grant order follows MEM_PORT_RR_ARB_EN when it is defined.
module tb_mem_port_router;
  import mem_port_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int CH_ID_LSB = 6;
  localparam int MAX_OUT   = 3;

  logic              clk;
  logic              reset;
  request_t          ch_req [NUM_CH];
  logic [NUM_CH-1:0] grant;
  request_t          ch_rsp [NUM_CH];
  request_t          mem_req;
  logic              mem_req_ready;
  request_t          mem_rsp;
  logic              route_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_router #(
    .NUM_CH          (NUM_CH),
    .CH_ID_LSB       (CH_ID_LSB),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ch_req        (ch_req),
    .grant         (grant),
    .ch_rsp        (ch_rsp),
    .mem_req       (mem_req),
    .mem_req_ready (mem_req_ready),
    .mem_rsp       (mem_rsp),
    .route_err     (route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic request_t mk_req(input int ch, input int tag);
    request_t r;
    r           = '0;
    r.vld       = 1'b1;
    r.addr      = 32'(32'h1000 * (ch + 1) + tag);
    r.data      = 32'(tag);
    r.access_id = 16'((ch << CH_ID_LSB) | tag);
    return r;
  endfunction

  function automatic request_t mk_rsp(input int field, input int tag);
    request_t r;
    r           = '0;
    r.vld       = 1'b1;
    r.addr      = 32'(32'h8000 + tag);
    r.data      = 32'(32'hD000 + tag);
    r.access_id = 16'((field << CH_ID_LSB) | tag);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] rsp_vlds();
    return {ch_rsp[2].vld, ch_rsp[1].vld, ch_rsp[0].vld};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NUM_CH; i++) ch_req[i] = '0;
    mem_rsp       = '0;
    mem_req_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    ch_req[0] = mk_req(0, 1);
    #1;
    n_checks++;
    if (mem_req !== request_t'(0)) $display("[TB] FAIL reset_mem_req: got %h expected 0", mem_req);
    else n_pass++;
    n_checks++;
    if (rsp_vlds() !== 3'b000) $display("[TB] FAIL reset_rsp_vld: got %b expected 000", rsp_vlds());
    else n_pass++;
    n_checks++;
    if (route_err !== 1'b0) $display("[TB] FAIL reset_route_err: got %b expected 0", route_err);
    else n_pass++;
    n_checks++;
    if (grant !== 3'b000) $display("[TB] FAIL reset_grant: got %b expected 000", grant);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_priority();
    logic [NUM_CH-1:0] exp_g [3];
    logic [31:0]       exp_addr;
`ifdef MEM_PORT_RR_ARB_EN
    exp_g = '{3'b001, 3'b010, 3'b001};
`else
    exp_g = '{3'b001, 3'b001, 3'b001};
`endif
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ch_req[0] = mk_req(0, c);
      ch_req[1] = mk_req(1, 0);
      settle();
      n_checks++;
      if (grant !== exp_g[c]) $display("[TB] FAIL prio_grant c%0d: got %b expected %b", c, grant, exp_g[c]);
      else n_pass++;
      exp_addr = (exp_g[c] == 3'b001) ? mk_req(0, c).addr : mk_req(1, 0).addr;
      step();
      n_checks++;
      if (mem_req.vld !== 1'b1 || mem_req.addr !== exp_addr)
        $display("[TB] FAIL prio_mem_req c%0d: got vld=%b addr=%h expected vld=1 addr=%h", c, mem_req.vld, mem_req.addr, exp_addr);
      else n_pass++;
    end
    ch_req[0] = '0;
    settle();
    n_checks++;
    if (grant !== 3'b010) $display("[TB] FAIL prio_ch1_grant: got %b expected 010", grant);
    else n_pass++;
    step();
    n_checks++;
    if (mem_req.vld !== 1'b1 || mem_req.addr !== mk_req(1, 0).addr)
      $display("[TB] FAIL prio_ch1_mem_req: got vld=%b addr=%h expected vld=1 addr=%h", mem_req.vld, mem_req.addr, mk_req(1, 0).addr);
    else n_pass++;
    ch_req[1] = '0;
    settle();
    step();
    n_checks++;
    if (mem_req.vld !== 1'b0) $display("[TB] FAIL prio_slot_empty: got vld=%b expected 0", mem_req.vld);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_req[1] = mk_req(1, 5);
    settle();
    n_checks++;
    if (grant !== 3'b010) $display("[TB] FAIL bp_first_grant: got %b expected 010", grant);
    else n_pass++;
    step();
    ch_req[1]     = '0;
    ch_req[0]     = mk_req(0, 7);
    mem_req_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      n_checks++;
      if (grant !== 3'b000) $display("[TB] FAIL bp_grant c%0d: got %b expected 000", c, grant);
      else n_pass++;
      n_checks++;
      if (mem_req.vld !== 1'b1 || mem_req.addr !== mk_req(1, 5).addr)
        $display("[TB] FAIL bp_hold c%0d: got vld=%b addr=%h expected vld=1 addr=%h", c, mem_req.vld, mem_req.addr, mk_req(1, 5).addr);
      else n_pass++;
      step();
    end
    mem_req_ready = 1'b1;
    settle();
    n_checks++;
    if (grant !== 3'b001) $display("[TB] FAIL bp_release_grant: got %b expected 001", grant);
    else n_pass++;
    step();
    n_checks++;
    if (mem_req.vld !== 1'b1 || mem_req.addr !== mk_req(0, 7).addr)
      $display("[TB] FAIL bp_next_req: got vld=%b addr=%h expected vld=1 addr=%h", mem_req.vld, mem_req.addr, mk_req(0, 7).addr);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int c = 0; c < MAX_OUT; c++) begin
      ch_req[0] = mk_req(0, c);
      settle();
      n_checks++;
      if (grant !== 3'b001) $display("[TB] FAIL out_grant c%0d: got %b expected 001", c, grant);
      else n_pass++;
      step();
    end
    ch_req[0] = mk_req(0, 9);
    settle();
    n_checks++;
    if (grant !== 3'b000) $display("[TB] FAIL out_limit: got %b expected 000", grant);
    else n_pass++;
    step();
    mem_rsp = mk_rsp(0, 4);
    settle();
    n_checks++;
    if (grant !== 3'b000) $display("[TB] FAIL out_limit_rsp_cycle: got %b expected 000", grant);
    else n_pass++;
    step();
    mem_rsp = '0;
    settle();
    n_checks++;
    if (ch_rsp[0].vld !== 1'b1 || ch_rsp[0].data !== mk_rsp(0, 4).data)
      $display("[TB] FAIL out_rsp0: got vld=%b data=%h expected vld=1 data=%h", ch_rsp[0].vld, ch_rsp[0].data, mk_rsp(0, 4).data);
    else n_pass++;
    n_checks++;
    if (grant !== 3'b001) $display("[TB] FAIL out_regrant: got %b expected 001", grant);
    else n_pass++;
    step();
    ch_req[0] = '0;
    n_checks++;
    if (ch_rsp[0].vld !== 1'b0) $display("[TB] FAIL out_rsp_pulse: got vld=%b expected 0", ch_rsp[0].vld);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_routing();
    do_reset();
    for (int c = 1; c <= 2; c++) begin
      ch_req[1] = mk_req(1, c);
      settle();
      step();
    end
    ch_req[1] = '0;
    mem_rsp   = mk_rsp(1, 1);
    settle();
    step();
    mem_rsp = '0;
    n_checks++;
    if (rsp_vlds() !== 3'b010 || ch_rsp[1].data !== mk_rsp(1, 1).data)
      $display("[TB] FAIL route_ch1: got vlds=%b data=%h expected vlds=010 data=%h", rsp_vlds(), ch_rsp[1].data, mk_rsp(1, 1).data);
    else n_pass++;
    n_checks++;
    if (route_err !== 1'b0) $display("[TB] FAIL route_err_clean: got %b expected 0", route_err);
    else n_pass++;
    // grant and response on ch1 together: the count (1) must not move
    ch_req[1] = mk_req(1, 3);
    mem_rsp   = mk_rsp(1, 2);
    settle();
    n_checks++;
    if (grant !== 3'b010) $display("[TB] FAIL route_simul_grant: got %b expected 010", grant);
    else n_pass++;
    step();
    mem_rsp = '0;
    for (int c = 4; c <= 5; c++) begin
      ch_req[1] = mk_req(1, c);
      settle();
      n_checks++;
      if (grant !== 3'b010) $display("[TB] FAIL route_fill c%0d: got %b expected 010", c, grant);
      else n_pass++;
      step();
    end
    ch_req[1] = mk_req(1, 6);
    settle();
    n_checks++;
    if (grant !== 3'b000) $display("[TB] FAIL route_simul_count: got %b expected 000", grant);
    else n_pass++;
    ch_req[1] = '0;
    mem_rsp   = mk_rsp(3, 9);
    step();
    mem_rsp = '0;
    n_checks++;
    if (rsp_vlds() !== 3'b000) $display("[TB] FAIL route_drop: got vlds=%b expected 000", rsp_vlds());
    else n_pass++;
    n_checks++;
    if (route_err !== 1'b1) $display("[TB] FAIL route_err_bad_idx: got %b expected 1", route_err);
    else n_pass++;
    step();
    n_checks++;
    if (route_err !== 1'b1) $display("[TB] FAIL route_err_sticky: got %b expected 1", route_err);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < MAX_OUT; c++) begin
      ch_req[0] = mk_req(0, c);
      settle();
      step();
    end
    ch_req[0]     = mk_req(0, 3);
    mem_req_ready = 1'b0;
    settle();
    n_checks++;
    if (mem_req.vld !== 1'b1) $display("[TB] FAIL mid_precond: got vld=%b expected 1", mem_req.vld);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== request_t'(0)) $display("[TB] FAIL mid_mem_req: got %h expected 0", mem_req);
    else n_pass++;
    n_checks++;
    if (grant !== 3'b000) $display("[TB] FAIL mid_grant: got %b expected 000", grant);
    else n_pass++;
    step();
    reset         = 1'b1;
    mem_req_ready = 1'b1;
    ch_req[0]     = '0;
    mem_rsp       = mk_rsp(0, 2);
    settle();
    step();
    mem_rsp = '0;
    n_checks++;
    if (ch_rsp[0].vld !== 1'b1 || route_err !== 1'b1)
      $display("[TB] FAIL mid_late_rsp: got vld=%b route_err=%b expected vld=1 route_err=1", ch_rsp[0].vld, route_err);
    else n_pass++;
    for (int c = 0; c <= MAX_OUT; c++) begin
      ch_req[0] = mk_req(0, c);
      settle();
      n_checks++;
      if (grant !== ((c < MAX_OUT) ? 3'b001 : 3'b000))
        $display("[TB] FAIL mid_counter c%0d: got %b expected %b", c, grant, (c < MAX_OUT) ? 3'b001 : 3'b000);
      else n_pass++;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_backpressure();
    test_outstanding();
    test_routing();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
